// File: rtl/xadc_pkg.sv
// -----------------------------------------------------------------------------
// xadc_pkg : shared DRP widths, FSM state type and XADC register addresses. rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package xadc_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } drp_state_t;

    localparam logic [DRP_ADDR_W-1:0] ADDR_TEMP   = 7'h00;
    localparam logic [DRP_ADDR_W-1:0] ADDR_VCCINT = 7'h01;
    localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX3  = 7'h13;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CFG0   = 7'h40;

    // Index width that stays legal when only one requester exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xadc_drp_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first set request at or above ptr. rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import xadc_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        valid_o = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid_o && req_i[wrap_add(ptr_i, k)]) begin
                valid_o                    = 1'b1;
                idx_o                      = wrap_add(ptr_i, k);
                gnt_o[wrap_add(ptr_i, k)]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/xadc_drp_arbiter.sv
// -----------------------------------------------------------------------------
// xadc_drp_arbiter : shares one XADC DRP among NREQ requesters, one access per handshake. rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module xadc_drp_arbiter
    import xadc_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = DRP_ADDR_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ-1:0]                     req_we,
    input  logic [NREQ-1:0][ADDR_W-1:0]         req_addr,
    input  logic [NREQ-1:0][DRP_DATA_W-1:0]     req_wdata,
    output logic [NREQ-1:0]                     ack,
    output logic [DRP_DATA_W-1:0]               rdata,
    output logic                                err,
    output logic                                busy,
    output logic                                drp_den,
    output logic                                drp_dwe,
    output logic [ADDR_W-1:0]                   drp_daddr,
    output logic [DRP_DATA_W-1:0]               drp_di,
    input  logic                                drp_drdy,
    input  logic [DRP_DATA_W-1:0]               drp_do
);

    localparam int                IDX_W    = idx_width(NREQ);
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NREQ - 1);

    drp_state_t             state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic                   we_q, we_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic [DRP_DATA_W-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   den_q, den_d;
    logic                   dwe_q, dwe_d;
    logic [ADDR_W-1:0]      daddr_q, daddr_d;
    logic [DRP_DATA_W-1:0]  di_q, di_d;

    logic                   arb_valid;
    logic [NREQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]       arb_idx;

    rr_arbiter #(
        .NREQ   (NREQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req_i   (req),
        .ptr_i   (rr_q),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
        end
    end

    // Outputs are registered, so each one is loaded on the transition into the
    // state where it must be visible (den/dwe/daddr/di on entry to ISSUE, ack on entry to DONE).
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        busy_d  = busy_q;
        den_d   = 1'b0;
        dwe_d   = 1'b0;
        daddr_d = daddr_q;
        di_d    = di_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gidx_d  = arb_idx;
                    gnt_d   = arb_gnt;
                    we_d    = req_we[arb_idx];
                    daddr_d = req_addr[arb_idx];
                    di_d    = req_wdata[arb_idx];
                    den_d   = 1'b1;
                    dwe_d   = req_we[arb_idx];
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (drp_drdy) begin
                    rdata_d = we_q ? '0 : drp_do;
                    err_d   = 1'b0;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                rr_d    = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_arbiter : random + directed bench with a transaction-timestamp reference model. rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_xadc_drp_arbiter;
    import xadc_pkg::*;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;
    localparam int ADDR_W  = 7;
    localparam int HALF    = 5;

    logic                       clk;
    logic                       rst;
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            req_we;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][15:0]      req_wdata;
    logic [NREQ-1:0]            ack;
    logic [15:0]                rdata;
    logic                       err;
    logic                       busy;
    logic                       drp_den;
    logic                       drp_dwe;
    logic [ADDR_W-1:0]          drp_daddr;
    logic [15:0]                drp_di;
    logic                       drp_drdy;
    logic [15:0]                drp_do;

    xadc_drp_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_daddr (drp_daddr),
        .drp_di    (drp_di),
        .drp_drdy  (drp_drdy),
        .drp_do    (drp_do)
    );

    initial begin
        clk = 1'b0;
        forever #HALF clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: per-requester state (0 idle, 1 waiting, 2 in service)
    // and timestamps of the single outstanding transaction.
    int          st[NREQ];
    bit          dropped[NREQ];
    bit          op_we[NREQ];
    logic [6:0]  op_addr[NREQ];
    logic [15:0] op_wd[NREQ];
    int          ptr, g, den_cyc, ack_cyc, drdy_cyc, done_cyc, grant_cyc;
    bit          in_flight;
    logic [15:0] do_val, exp_rdata, last_rdata, last_di;
    logic [6:0]  last_daddr;
    bit          exp_err;
    bit          rand_en, stray_en, fixed_do_en;
    int          lat_mode;
    logic [15:0] fixed_do;

    int          obs_den_cyc, obs_ack_cyc, obs_ack_idx;
    bit          obs_dwe, obs_err;
    logic [15:0] obs_di, obs_rdata;
    int          ack_order[$];

    int          n_checks, n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic post(input int i, input bit we, input logic [6:0] a, input logic [15:0] d);
        st[i]      = 1;
        dropped[i] = 1'b0;
        op_we[i]   = we;
        op_addr[i] = a;
        op_wd[i]   = d;
    endtask

    task automatic reset_model();
        for (int i = 0; i < NREQ; i++) begin
            st[i]      = 0;
            dropped[i] = 1'b0;
        end
        ptr        = 0;
        in_flight  = 1'b0;
        done_cyc   = -1;
        last_rdata = '0;
        last_daddr = '0;
        last_di    = '0;
    endtask

    task automatic check_outputs(input int n);
        bit              e_den, e_busy;
        logic [NREQ-1:0] e_ack;
        e_den  = in_flight && (n == den_cyc);
        e_busy = in_flight && (n >= den_cyc);
        e_ack  = '0;
        if (in_flight && n == ack_cyc) e_ack[g] = 1'b1;
        if (e_den) begin
            last_daddr = op_addr[g];
            last_di    = op_wd[g];
        end
        if (drp_den) begin
            obs_den_cyc = n;
            obs_dwe     = drp_dwe;
            obs_di      = drp_di;
        end
        if (ack != '0) begin
            obs_ack_cyc = n;
            obs_err     = err;
            obs_rdata   = rdata;
            for (int i = 0; i < NREQ; i++) if (ack[i]) obs_ack_idx = i;
            ack_order.push_back(obs_ack_idx);
        end
        check("den",   32'(drp_den), 32'(e_den));
        check("dwe",   32'(drp_dwe), 32'(e_den && op_we[g]));
        check("daddr", 32'(drp_daddr), 32'(last_daddr));
        check("di",    32'(drp_di), 32'(last_di));
        check("busy",  32'(busy), 32'(e_busy));
        check("ack",   32'(ack), 32'(e_ack));
        if (e_ack != '0) begin
            last_rdata = exp_rdata;
            check("err", 32'(err), 32'(exp_err));
        end
        check("rdata", 32'(rdata), 32'(last_rdata));
    endtask

    task automatic update_stimulus(input int n);
        bit found;
        int gi, lat, r;
        if (in_flight && n == ack_cyc) begin
            ptr        = (g + 1) % NREQ;
            st[g]      = 0;
            dropped[g] = 1'b0;
            in_flight  = 1'b0;
            done_cyc   = n;
        end
        if (rand_en) begin
            for (int i = 0; i < NREQ; i++)
                if (st[i] == 0 && $urandom_range(3) == 0)
                    post(i, 1'($urandom_range(1)), 7'($urandom), 16'($urandom));
            if (in_flight && !dropped[g] && n >= den_cyc && $urandom_range(7) == 0)
                dropped[g] = 1'b1;
        end
        if (!in_flight && n > done_cyc) begin
            found = 1'b0;
            gi    = 0;
            for (int k = 0; k < NREQ; k++)
                if (!found && st[(ptr + k) % NREQ] == 1) begin
                    found = 1'b1;
                    gi    = (ptr + k) % NREQ;
                end
            if (found) begin
                g         = gi;
                st[g]     = 2;
                in_flight = 1'b1;
                grant_cyc = n;
                den_cyc   = n + 1;
                lat       = lat_mode;
                if (lat < 0) begin
                    r   = $urandom_range(15);
                    lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT : 1 + $urandom_range(5);
                end
                do_val = fixed_do_en ? fixed_do : 16'($urandom);
                if (lat == 0) begin
                    drdy_cyc  = -1;
                    ack_cyc   = den_cyc + TIMEOUT + 1;
                    exp_rdata = '0;
                    exp_err   = 1'b1;
                end else begin
                    drdy_cyc  = den_cyc + lat;
                    ack_cyc   = drdy_cyc + 1;
                    exp_rdata = op_we[g] ? 16'h0 : do_val;
                    exp_err   = 1'b0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i]       = (st[i] == 1) || (st[i] == 2 && !dropped[i]);
            req_we[i]    = op_we[i];
            req_addr[i]  = op_addr[i];
            req_wdata[i] = op_wd[i];
        end
        if (in_flight && n == drdy_cyc) begin
            drp_drdy = 1'b1;
            drp_do   = do_val;
        end else begin
            drp_do   = 16'($urandom);
            drp_drdy = stray_en && (!in_flight || n <= den_cyc || n >= ack_cyc)
                       && ($urandom_range(3) == 0);
        end
    endtask

    task automatic step();
        int n;
        @(negedge clk);
        n = cyc;
        check_outputs(n);
        update_stimulus(n);
    endtask

    task automatic run_quiet(input int max_cycles);
        int active;
        int k;
        k = 0;
        active = 1;
        while (active != 0 && k < max_cycles) begin
            step();
            k++;
            active = int'(in_flight);
            for (int i = 0; i < NREQ; i++) if (st[i] != 0) active++;
        end
        if (k >= max_cycles) check("quiet_bound", 32'(active), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        req         = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        drp_drdy    = 1'b0;
        drp_do      = '0;
        rand_en     = 1'b0;
        stray_en    = 1'b0;
        fixed_do_en = 1'b0;
        fixed_do    = '0;
        lat_mode    = 1;
        g           = 0;
        den_cyc     = 0;
        ack_cyc     = 0;
        drdy_cyc    = -1;
        grant_cyc   = 0;
        exp_rdata   = '0;
        exp_err     = 1'b0;
        obs_den_cyc = 0;
        obs_ack_cyc = 0;
        obs_ack_idx = -1;
        obs_dwe     = 1'b0;
        obs_err     = 1'b0;
        obs_di      = '0;
        obs_rdata   = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_we[i]   = 1'b0;
            op_addr[i] = '0;
            op_wd[i]   = '0;
        end
        reset_model();
        repeat (3) step();
        #2 rst = 1'b0;

        // Single read, data three cycles after den.
        lat_mode = 3; fixed_do_en = 1'b1; fixed_do = 16'hA5C0;
        post(0, 1'b0, ADDR_VAUX3, 16'h0);
        run_quiet(100);
        check("t1_den_lat",  32'(obs_den_cyc - grant_cyc), 32'd1);
        check("t1_ack_lat",  32'(obs_ack_cyc - grant_cyc), 32'd5);
        check("t1_rdata",    32'(obs_rdata), 32'hA5C0);
        check("t1_err",      32'(obs_err), 32'd0);

        // Write on requester 1, drdy after one cycle.
        lat_mode = 1;
        post(1, 1'b1, ADDR_CFG0, 16'h1234);
        run_quiet(100);
        check("t3_dwe",   32'(obs_dwe), 32'd1);
        check("t3_di",    32'(obs_di), 32'h1234);
        check("t3_idx",   32'(obs_ack_idx), 32'd1);
        check("t3_rdata", 32'(obs_rdata), 32'd0);
        check("t3_err",   32'(obs_err), 32'd0);

        // Serve the last requester so the pointer wraps back to 0.
        lat_mode = 2;
        post(2, 1'b0, ADDR_VCCINT, 16'h0);
        run_quiet(100);

        // Contention between requesters 0 and 1 starting at pointer 0.
        begin
            int posts;
            int k;
            ack_order.delete();
            post(0, 1'b0, ADDR_TEMP, 16'h0);
            post(1, 1'b0, ADDR_VAUX3, 16'h0);
            posts = 2;
            k = 0;
            while (ack_order.size() < 4 && k < 200) begin
                step();
                k++;
                for (int i = 0; i < 2; i++)
                    if (st[i] == 0 && posts < 4) begin
                        post(i, 1'b0, 7'(i + 1), 16'h0);
                        posts++;
                    end
            end
            run_quiet(100);
            check("t2_count", 32'(ack_order.size()), 32'd4);
            for (int i = 0; i < ack_order.size() && i < 4; i++)
                check("t2_order", 32'(ack_order[i]), 32'(i % 2));
        end

        // Timeout, then a normal access.
        lat_mode = 0;
        post(0, 1'b0, ADDR_TEMP, 16'h0);
        run_quiet(200);
        check("t4_gap",   32'(obs_ack_cyc - obs_den_cyc), 32'(TIMEOUT + 1));
        check("t4_err",   32'(obs_err), 32'd1);
        check("t4_rdata", 32'(obs_rdata), 32'd0);
        lat_mode = 1; fixed_do = 16'h0BEE;
        post(1, 1'b0, ADDR_VCCINT, 16'h0);
        run_quiet(100);
        check("t4_next_err",   32'(obs_err), 32'd0);
        check("t4_next_rdata", 32'(obs_rdata), 32'h0BEE);

        // drdy on the final WAIT cycle beats the timeout.
        lat_mode = TIMEOUT; fixed_do = 16'hFFF0;
        post(0, 1'b0, ADDR_VAUX3, 16'h0);
        run_quiet(200);
        check("t5_gap",   32'(obs_ack_cyc - obs_den_cyc), 32'(TIMEOUT + 1));
        check("t5_err",   32'(obs_err), 32'd0);
        check("t5_rdata", 32'(obs_rdata), 32'hFFF0);

        // Asynchronous reset in the middle of WAIT; pointer is 1 going in.
        lat_mode = 0;
        post(1, 1'b0, ADDR_CFG0, 16'h0);
        for (int k = 0; k < 20 && !(in_flight && cyc >= den_cyc + 3); k++) step();
        #2 rst = 1'b1;
        #1;
        check("t6_busy",  32'(busy), 32'd0);
        check("t6_ack",   32'(ack), 32'd0);
        check("t6_den",   32'(drp_den), 32'd0);
        check("t6_dwe",   32'(drp_dwe), 32'd0);
        check("t6_err",   32'(err), 32'd0);
        check("t6_rdata", 32'(rdata), 32'd0);
        check("t6_daddr", 32'(drp_daddr), 32'd0);
        reset_model();
        step();
        step();
        #2 rst = 1'b0;
        drp_drdy = 1'b1;
        drp_do   = 16'hDEAD;
        stray_en = 1'b1;
        repeat (4) step();
        stray_en = 1'b0;
        ack_order.delete();
        lat_mode = 1; fixed_do_en = 1'b0;
        post(0, 1'b0, ADDR_TEMP, 16'h0);
        post(1, 1'b0, ADDR_VAUX3, 16'h0);
        run_quiet(100);
        check("t6_count", 32'(ack_order.size()), 32'd2);
        if (ack_order.size() >= 2) begin
            check("t6_first",  32'(ack_order[0]), 32'd0);
            check("t6_second", 32'(ack_order[1]), 32'd1);
        end

        // Randomized traffic with drops, stray drdy, timeouts and coincident cases.
        rand_en = 1'b1; stray_en = 1'b1; lat_mode = -1;
        repeat (3000) step();
        rand_en = 1'b0;
        run_quiet(500);
        stray_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
